// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: digit scan scheduler for a 4-digit multiplexed 7-segment display.
// Steps a digit index once per scan slot, drives the active-low commons and the
// mux select, generates the blink timing and the decimal-point drive.
module fnd_scan_ctrl #(
    parameter int SCAN_DIV  = 100000,  // clk cycles per digit slot, >= 2
    parameter int BLINK_DIV = 500      // scan ticks per blink half-period, >= 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blink_en,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_mask,
    output logic [2:0] sel,
    output logic [3:0] fnd_com,
    output logic       dp_n,
    output logic       scan_tick,
    output logic       blink_phase
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [2:0]    SEL_BLANK  = 3'b100;

    logic [DW-1:0] r_div_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic          r_scan_tick;
    logic [2:0]    r_sel;
    logic [3:0]    r_fnd_com;
    logic          r_dp_n;

    logic [3:0]    w_digit_hot;
    logic          w_blank;
    logic [2:0]    w_sel_next;
    logic [3:0]    w_fnd_com_next;
    logic          w_dp_n_next;

    // One-hot decode of the current digit index; commons are its inverse.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit_hot
            assign w_digit_hot[gi] = (r_idx == 2'(gi));
        end
    endgenerate

    // Slot divider; scan_tick is the registered wrap flag, so it lands one clk
    // after the divider reaches its last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_scan_tick <= 1'b0;
        end else begin
            r_scan_tick <= (r_div_cnt == DIV_LAST);
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Digit index advances on every scan tick, independent of the display enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 2'd0;
        end else if (r_scan_tick) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Blink timer: counts scan ticks while blinking is enabled and toggles the
    // phase on wrap; disabling blinking restarts the count and shows the digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (!blink_en) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_scan_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Next values of the pin-facing outputs from the current index, phase and inputs.
    always_comb begin
        w_blank        = blink_en & ~r_blink_phase & blink_mask[r_idx];
        w_sel_next     = {1'b0, r_idx};
        w_fnd_com_next = ~w_digit_hot;
        w_dp_n_next    = ~(en & ~w_blank & dp_mask[r_idx]);
        if (!en || w_blank) begin
            w_sel_next = SEL_BLANK;
        end
        // Blinking only blanks the mux value; the common stays driven.
        if (!en) begin
            w_fnd_com_next = 4'b1111;
        end
    end

    // Output registers reload every clk so any input change shows one clk later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel     <= SEL_BLANK;
            r_fnd_com <= 4'b1111;
            r_dp_n    <= 1'b1;
        end else begin
            r_sel     <= w_sel_next;
            r_fnd_com <= w_fnd_com_next;
            r_dp_n    <= w_dp_n_next;
        end
    end

    assign sel         = r_sel;
    assign fnd_com     = r_fnd_com;
    assign dp_n        = r_dp_n;
    assign scan_tick   = r_scan_tick;
    assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed and randomized checks of fnd_scan_ctrl against a
// timeline model (edge count since reset release, ticks seen while blinking).
module tb_fnd_scan_ctrl;

    localparam int SD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       blink_en;
    logic [3:0] blink_mask;
    logic [3:0] dp_mask;
    logic [2:0] sel;
    logic [3:0] fnd_com;
    logic       dp_n;
    logic       scan_tick;
    logic       blink_phase;

    fnd_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .sel        (sel),
        .fnd_com    (fnd_com),
        .dp_n       (dp_n),
        .scan_tick  (scan_tick),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: edges since reset release, scan ticks seen while blink_en held.
    int         m_n;
    int         m_bticks;
    bit         m_phase;
    bit         m_tick;
    logic [2:0] e_sel;
    logic [3:0] e_com;
    bit         e_dp;

    // Digit index in effect after n edges since release.
    function automatic int idx_of(int n);
        return (n == 0) ? 0 : ((n - 1) / SD) % 4;
    endfunction

    task automatic model_reset();
        m_n = 0; m_bticks = 0; m_phase = 1'b1; m_tick = 1'b0;
        e_sel = 3'b100; e_com = 4'b1111; e_dp = 1'b1;
    endtask

    // Advance the model across the upcoming rising edge using the current inputs.
    task automatic model_step();
        int  idx;
        bit  blank;
        if (reset) begin
            model_reset();
        end else begin
            idx   = idx_of(m_n);
            blank = blink_en && !m_phase && blink_mask[idx];
            e_sel = (!en || blank) ? 3'b100 : 3'(idx);
            e_com = en ? ~(4'b0001 << idx) : 4'b1111;
            e_dp  = !(en && !blank && dp_mask[idx]);
            if (!blink_en) m_bticks = 0;
            else if (m_tick) m_bticks++;
            m_phase = ((m_bticks / BD) % 2) == 0;
            m_n++;
            m_tick = (m_n % SD) == 0;
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("sel", int'(sel), int'(e_sel));
        check("fnd_com", int'(fnd_com), int'(e_com));
        check("dp_n", int'(dp_n), int'(e_dp));
        check("scan_tick", int'(scan_tick), int'(m_tick));
        check("blink_phase", int'(blink_phase), int'(m_phase));
    endtask

    // One clock: model across the edge, then compare 1 time unit after it.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    // Assert reset between edges, verify outputs respond without a clock, hold, release.
    task automatic async_reset(int hold);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < hold; i++) cycle();
        reset = 1'b0;
    endtask

    int         first_tick;
    int         tick_count;
    logic [2:0] sel_hist [1:20];
    logic [3:0] com_hist [1:20];
    int         toggles [$];
    bit         prev_phase;
    bit         seen_blank;
    int         dp_bad;
    int         dp_low_seen;

    initial begin
        reset = 1'b1; en = 1'b0; blink_en = 1'b0; blink_mask = 4'h0; dp_mask = 4'h0;
        model_reset();
        cycle(); cycle();

        // Scan timing and digit stepping from reset release.
        en = 1'b1;
        reset = 1'b0;
        first_tick = 0; tick_count = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (scan_tick) begin
                tick_count++;
                if (first_tick == 0) first_tick = k;
            end
            sel_hist[k] = sel;
            com_hist[k] = fnd_com;
        end
        check("first_tick_edge", first_tick, 4);
        check("tick_count_20", tick_count, 5);
        check("sel_at_7", int'(sel_hist[7]), 1);
        check("sel_at_11", int'(sel_hist[11]), 2);
        check("com_at_15", int'(com_hist[15]), 4'b0111);
        check("sel_at_18", int'(sel_hist[18]), 0);
        $display("step scan: first tick at edge %0d, %0d ticks", first_tick, tick_count);

        // Reset pulse in the middle of a slot.
        cycle();
        async_reset(2);
        for (int k = 0; k < 6; k++) cycle();
        $display("step mid-slot reset done at cycle %0d", cyc);

        // Blinking of digit 0.
        blink_en = 1'b1; blink_mask = 4'b0001;
        toggles.delete();
        seen_blank = 1'b0;
        prev_phase = blink_phase;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (blink_phase != prev_phase) toggles.push_back(cyc);
            prev_phase = blink_phase;
            if (sel == 3'b100 && fnd_com == 4'b1110) seen_blank = 1'b1;
        end
        check("blink_toggles_ge2", int'(toggles.size() >= 2), 1);
        if (toggles.size() >= 2) check("blink_half_period", toggles[1] - toggles[0], 8);
        check("blank_digit0_seen", int'(seen_blank), 1);
        $display("step blink: %0d phase toggles", toggles.size());

        // Decimal point on digit 2 with blinking off.
        blink_en = 1'b0; blink_mask = 4'h0; dp_mask = 4'b0100;
        cycle();
        dp_bad = 0; dp_low_seen = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if ((dp_n == 1'b0) != (sel == 3'b010)) dp_bad++;
            if (dp_n == 1'b0) dp_low_seen++;
        end
        check("dp_follows_digit2", dp_bad, 0);
        check("dp_low_cycles", dp_low_seen, 4);
        $display("step dp: %0d cycles with dp lit", dp_low_seen);

        // Blink digit 2 with its dp lit, then drop en for 10 clocks.
        blink_en = 1'b1; blink_mask = 4'b0100;
        for (int k = 0; k < 24; k++) cycle();
        en = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        en = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        $display("step en drop done at cycle %0d", cyc);

        // Randomized inputs with occasional mid-slot resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15, 0) == 0) en = ~en;
            if ($urandom_range(19, 0) == 0) blink_en = ~blink_en;
            if ($urandom_range(9, 0) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(9, 0) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(299, 0) == 0) async_reset(int'($urandom_range(3, 1)));
            cycle();
        end
        $display("step random: done at cycle %0d", cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
